// File: rtl/xadac_dispatch_if.sv
// ============================================================================
// Module   : xadac_dispatch_if
// Brief    : Core-request, unit-dispatch and response bundle for xadac_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xadac_dispatch_if #(
  parameter int NoUnits   = 4,
  parameter int IdWidth   = 4,
  parameter int DataWidth = 128
);
  logic                           req_valid;
  logic                           req_ready;
  logic [31:0]                    req_instr;
  logic [IdWidth-1:0]             req_id;
  logic [NoUnits-1:0]             unit_req_valid;
  logic [NoUnits-1:0]             unit_req_ready;
  logic [31:0]                    unit_req_instr;
  logic [IdWidth-1:0]             unit_req_id;
  logic [NoUnits-1:0]             unit_rsp_valid;
  logic [NoUnits-1:0]             unit_rsp_ready;
  logic [NoUnits*DataWidth-1:0]   unit_rsp_data;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [IdWidth-1:0]             rsp_id;
  logic [DataWidth-1:0]           rsp_data;
  logic                           rsp_err;

  // The dispatcher itself.
  modport slave (
    input  req_valid, req_instr, req_id, unit_req_ready,
           unit_rsp_valid, unit_rsp_data, rsp_ready,
    output req_ready, unit_req_valid, unit_req_instr, unit_req_id,
           unit_rsp_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // The surrounding core and execution units.
  modport master (
    output req_valid, req_instr, req_id, unit_req_ready,
           unit_rsp_valid, unit_rsp_data, rsp_ready,
    input  req_ready, unit_req_valid, unit_req_instr, unit_req_id,
           unit_rsp_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/xadac_dispatch.sv
// ============================================================================
// Module   : xadac_dispatch
// Brief    : Mask/match decode of accelerator instructions to NoUnits units with
//            in-order response return; XADAC_DISPATCH_PERF_EN adds perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadac_dispatch #(
  parameter int                    NoUnits        = 4,
  parameter logic [NoUnits*32-1:0] Mask           = {32'h00003077, 32'h0000707f,
                                                     32'h01f0707f, 32'h01f0707f},
  parameter logic [NoUnits*32-1:0] Match          = {32'h00003077, 32'h00002077,
                                                     32'h00001077, 32'h00000077},
  parameter int                    MaxOutstanding = 4,
  parameter int                    IdWidth        = 4,
  parameter int                    DataWidth      = 128
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  xadac_dispatch_if.slave      bus
`ifdef XADAC_DISPATCH_PERF_EN
  ,
  output logic [NoUnits*32-1:0] perf_dispatch_cnt,
  output logic [31:0]           perf_err_cnt,
  output logic [31:0]           perf_full_stall_cnt
`endif
);

  localparam int IdxW = (NoUnits > 1) ? $clog2(NoUnits) : 1;
  localparam int AdrW = $clog2(MaxOutstanding);
  localparam int PtrW = AdrW + 1;

  logic [NoUnits-1:0] w_hit;
  logic [IdxW-1:0]    w_tgt;
  logic               w_any_hit;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]    fifo_unit_q [MaxOutstanding];
  logic [IdWidth-1:0] fifo_id_q   [MaxOutstanding];
  logic               fifo_err_q  [MaxOutstanding];

  logic [IdxW-1:0]    w_head_unit;
  logic [IdWidth-1:0] w_head_id;
  logic               w_head_err;

  for (genvar i = 0; i < NoUnits; i++) begin : g_hit
    assign w_hit[i] = ((bus.req_instr & Mask[i*32 +: 32]) == Match[i*32 +: 32]);
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_tgt     = '0;
    w_any_hit = 1'b0;
    for (int i = NoUnits - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_tgt     = IdxW'(i);
        w_any_hit = 1'b1;
      end
    end
  end

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AdrW] != rd_ptr_q[AdrW]) &&
                   (wr_ptr_q[AdrW-1:0] == rd_ptr_q[AdrW-1:0]);

  // full alone gates acceptance, keeping rsp_ready out of the req_ready cone.
  always_comb begin
    bus.unit_req_valid = '0;
    bus.req_ready      = 1'b0;
    if (!w_full) begin
      if (w_any_hit) begin
        bus.unit_req_valid[w_tgt] = bus.req_valid;
        bus.req_ready             = bus.unit_req_ready[w_tgt];
      end else begin
        bus.req_ready = 1'b1;
      end
    end
  end

  assign bus.unit_req_instr = bus.req_instr;
  assign bus.unit_req_id    = bus.req_id;

  assign w_head_unit = fifo_unit_q[rd_ptr_q[AdrW-1:0]];
  assign w_head_id   = fifo_id_q[rd_ptr_q[AdrW-1:0]];
  assign w_head_err  = fifo_err_q[rd_ptr_q[AdrW-1:0]];

  always_comb begin
    bus.rsp_valid      = 1'b0;
    bus.rsp_err        = 1'b0;
    bus.rsp_id         = '0;
    bus.rsp_data       = '0;
    bus.unit_rsp_ready = '0;
    if (!w_empty) begin
      bus.rsp_id = w_head_id;
      if (w_head_err) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end else begin
        bus.rsp_valid                   = bus.unit_rsp_valid[w_head_unit];
        bus.rsp_data                    = bus.unit_rsp_data[w_head_unit*DataWidth +: DataWidth];
        bus.unit_rsp_ready[w_head_unit] = bus.rsp_ready;
      end
    end
  end

  assign w_push   = bus.req_valid & bus.req_ready;
  assign w_pop    = bus.rsp_valid & bus.rsp_ready;
  assign wr_ptr_d = w_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  assign rd_ptr_d = w_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry payload needs no reset: it is only observed behind a non-empty pointer pair.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_unit_q[wr_ptr_q[AdrW-1:0]] <= w_tgt;
      fifo_id_q[wr_ptr_q[AdrW-1:0]]   <= bus.req_id;
      fifo_err_q[wr_ptr_q[AdrW-1:0]]  <= ~w_any_hit;
    end
  end

`ifdef XADAC_DISPATCH_PERF_EN
  logic [31:0] err_cnt_q;
  logic [31:0] stall_cnt_q;

  for (genvar i = 0; i < NoUnits; i++) begin : g_perf_unit
    logic [31:0] disp_cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        disp_cnt_q <= '0;
      end else if (w_push && w_any_hit && (w_tgt == IdxW'(i)) && (disp_cnt_q != '1)) begin
        disp_cnt_q <= disp_cnt_q + 32'd1;
      end
    end
    assign perf_dispatch_cnt[i*32 +: 32] = disp_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (w_push && !w_any_hit && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
      if (bus.req_valid && w_full && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_err_cnt        = err_cnt_q;
  assign perf_full_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/xadac_dispatch.md
Name: xadac_dispatch

Overview:
- Parametrised successor to the fixed five-way unit mux in the xadac accelerator top.
- Decodes each incoming accelerator instruction against per-unit mask/match pairs and dispatches it to exactly one of NoUnits execution units.
- Records the issue order and returns unit responses to the core strictly in that order, with a bounded number of instructions in flight.
- Instructions that match no unit get an in-order error response and are never dispatched, so no sink unit is needed.

Parameters:
- NoUnits, 4, number of execution units (1..16).
- Mask, {32'h00003077, 32'h0000707f, 32'h01f0707f, 32'h01f0707f}, packed NoUnits*32, per-unit decode mask; index 0 is the rightmost word.
- Match, {32'h00003077, 32'h00002077, 32'h00001077, 32'h00000077}, packed NoUnits*32, per-unit match value.
- MaxOutstanding, 4, depth of the order FIFO (power of two, >=2).
- IdWidth, 4, width of the request tag.
- DataWidth, 128, width of the response data.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- req_valid, in, 1, instruction valid.
- req_ready, out, 1, instruction accepted.
- req_instr, in, 32, instruction word.
- req_id, in, IdWidth, request tag.
- unit_req_valid, out, NoUnits, one-hot dispatch valid.
- unit_req_ready, in, NoUnits, unit accepts.
- unit_req_instr, out, 32, instruction, broadcast to all units.
- unit_req_id, out, IdWidth, tag, broadcast to all units.
- unit_rsp_valid, in, NoUnits, unit response valid.
- unit_rsp_ready, out, NoUnits, unit response ready.
- unit_rsp_data, in, NoUnits*DataWidth, unit response data; unit i occupies slice i.
- rsp_valid, out, 1, response to core.
- rsp_ready, in, 1, core accepts response.
- rsp_id, out, IdWidth, tag of the response.
- rsp_data, out, DataWidth, response data.
- rsp_err, out, 1, instruction was undecodable.

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous, active-low.
- Decode (combinational): hit[i] = ((req_instr & Mask[i]) == Match[i]). The target is the lowest index i with hit[i]. If no bit is set, the request takes the error path.
- Order FIFO: MaxOutstanding entries of {unit index, id, err}. Pointers are ceil(log2(MaxOutstanding))+1 bits wide and wrap naturally. full and empty are derived from the pointers.
- Dispatch:
  - unit_req_valid[t] = req_valid & ~full & hit-target==t.
  - unit_req_instr = req_instr and unit_req_id = req_id (zero-latency passthrough).
  - Hit path: req_ready = ~full & unit_req_ready[t].
  - Error path: req_ready = ~full, and all unit_req_valid bits are 0.
  - A request fire pushes one FIFO entry.
- full blocks acceptance even when a pop happens in the same cycle. This keeps req_ready independent of rsp_ready, so there is no combinational path from rsp_ready to req_ready.
- Response, driven from the head entry h when the FIFO is not empty:
  - Error entry: rsp_valid = 1, rsp_err = 1, rsp_data = 0, rsp_id = h.id; all unit_rsp_ready bits are 0.
  - Normal entry: rsp_valid = unit_rsp_valid[h.unit], rsp_data = slice h.unit, rsp_err = 0, rsp_id = h.id; unit_rsp_ready[h.unit] = rsp_ready, all other bits 0.
  - The head pops on rsp_valid & rsp_ready.
- Ordering:
  - A response from a non-head unit is stalled (its ready stays 0) until that unit's entry reaches the head.
  - Units must hold rsp_valid and data stable until ready.
- Latency:
  - Dispatch is 0 cycles.
  - The earliest response is the cycle after accept; the FIFO write is registered.
  - An error response appears the cycle after accept.
- Simultaneous push and pop when not full: both occur, and the occupancy count is unchanged.
- Reset, including mid-operation: FIFO is emptied and pointers cleared. rsp_valid = 0, rsp_err = 0, rsp_id = 0, rsp_data = 0. unit_rsp_ready = 0; unit_req_valid follows the combinational rules above. Responses in flight are discarded; units are reset by the same rstn.
- Empty FIFO: rsp_valid = 0 and rsp_data/rsp_id = 0, regardless of unit_rsp_valid.

Optional Feature:
- Macro: XADAC_DISPATCH_PERF_EN.
- When defined, adds the following outputs:
  - perf_dispatch_cnt[NoUnits*32]: per-unit accepted-instruction counters.
  - perf_err_cnt[32]: error-path accept counter.
  - perf_full_stall_cnt[32]: counts cycles with req_valid & full.
- All counters reset to 0, saturate at 2^32-1, and clear on rstn only.
- When not defined, these ports and their logic are absent; functional behaviour is identical.

Test Plan:
- Decode: req_instr=32'h00002077, id=3, all units ready -> unit_req_valid=4'b0100, accept in 1 cycle; unit 2 returns data 128'hA5 -> rsp_valid, rsp_id=3, rsp_data=128'hA5, rsp_err=0.
- Error path: req_instr=32'h00000033, id=7 -> no unit_req_valid; next cycle rsp_valid=1, rsp_err=1, rsp_id=7, rsp_data=0.
- Reordering:
  - Issue id1 to unit 0 (32'h00000077), then id2 to unit 1 (32'h00001077).
  - Unit 1 responds first -> unit_rsp_ready[1]=0 and rsp_valid=0 until unit 0 responds.
  - Responses emerge in order id1, then id2.
- Full: with rsp_ready=0, issue 4 hits -> 5th request sees req_ready=0. One rsp fire -> req_ready stays 0 in the pop cycle and rises the next cycle; the FIFO pointers wrap correctly over 10 iterations.
- Backpressure: unit_req_ready[3]=0 with req_instr=32'h00003077 -> req_ready=0, no FIFO push; unit ready rises -> single accept.
- Reset mid-operation: 3 entries outstanding, assert rstn low -> rsp_valid=0 immediately; after release the FIFO is empty and the next request is handled normally; with XADAC_DISPATCH_PERF_EN all counters read 0.
